dm_sized_pipe: RTL and testbench
================================

Name: dm_sized_pipe

Overview:
Parametrised successor to the single-cycle word data memory. Supports RISC-V RV32 sized accesses (byte/half/word, signed and unsigned loads) with byte-lane write masking and sign/zero extension. Reports misaligned, illegal-size and out-of-range accesses. Uses a valid/ready request channel and a configurable-latency response pipeline with backpressure. Sits behind the core's MEM stage, or a load/store unit, as the data-side RAM.

Parameters:
DEPTH, 64, number of 32-bit words; power of two, 16..4096
READ_LATENCY, 1, cycles from request acceptance to response valid; legal 1..4
ADDR_W, 32, byte-address width of req_addr

Ports:
clk  input  1  sole clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 access size/sign code
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
resp_err  output  1  access faulted; no memory side effect occurred

Behaviour:
- Accept: request accepted on a posedge where req_valid && req_ready.
- Responses: every accepted request yields exactly one response, in order.
- Pipeline: READ_LATENCY stages, each with a valid bit. resp_valid/resp_rdata/resp_err are driven from the last stage.
- Advance condition: advance = !(resp_valid && !resp_ready). All stages shift only when advance = 1; otherwise the whole pipeline freezes.
- req_ready = advance (combinational). No request is accepted while stalled.
- Response timing: a response appears exactly READ_LATENCY cycles after acceptance if never stalled. Each stall cycle adds one cycle.
- Bubbles: when advance = 1 and no request is accepted, a bubble (valid = 0) enters stage 1.
- funct3 codes:
  - 000: LB/SB
  - 001: LH/SH
  - 010: LW/SW
  - 100: LBU (load only)
  - 101: LHU (load only)
  - Any other code, or 100/101 with req_write = 1, is illegal and sets err.
- Alignment: half access needs addr[0] = 0; word access needs addr[1:0] = 00. Otherwise err.
- Range: req_addr >= 4*DEPTH sets err.
- Error effect: any err means no write, resp_rdata = 0, resp_err = 1.
- Word index: addr[log2(DEPTH)+1:2].
- Byte-lane writes:
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all 4 lanes.
  - Unwritten lanes keep their value.
- Write commit: the write happens on the accept edge.
- Load sampling: the array is sampled on the accept edge, so a load accepted the cycle after a store to the same word sees the new data. Lane select and extension are registered into stage 1 and carried unchanged down the pipe.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Stores: responses carry rdata = 0, err = 0 on success.
- Reset (rst_n low, async): all stage valid bits cleared. resp_valid = 0, resp_rdata = 0, resp_err = 0. req_ready = 1 once reset is released.
- Reset mid-operation: in-flight responses are discarded without being issued.
- Memory array is not reset; its contents are preserved across reset.
- Stall hold: while stalled, resp_rdata and resp_err hold stable.

Test Plan:
- READ_LATENCY = 1, resp_ready = 1:
  - SW 0xDEADBEEF @0x10, then LW @0x10 next cycle -> load response 0xDEADBEEF, err = 0.
  - The store response precedes it, one cycle apart.
- After the above, issue in sequence:
  - SB 0x7F @0x11 -> word = 0xDEAD7FEF.
  - LB @0x11 -> 0x0000007F.
  - LB @0x13 -> 0xFFFFFFDE.
  - LBU @0x13 -> 0x000000DE.
  - LHU @0x12 -> 0x0000DEAD.
  - LH @0x12 -> 0xFFFFDEAD.
- Faults:
  - SH @0x21 -> err = 1, word at 0x20 unchanged.
  - LW @0x22 -> err = 1, rdata = 0.
  - LW @0x100 with DEPTH = 64 -> err = 1.
  - funct3 = 011 -> err = 1.
  - SB with funct3 = 100 -> err = 1, no write.
- READ_LATENCY = 3, back-to-back loads A, B, C with resp_ready held low from the cycle A becomes valid for 2 cycles:
  - req_ready low during the stall.
  - A held stable.
  - A, B, C then delivered in order, one per cycle.
- rst_n pulsed low with 2 loads in flight:
  - resp_valid drops immediately and neither response appears.
  - req_ready = 1 after release.
  - A subsequent LW returns the pre-reset stored data.

Source files
------------

// File: rtl/dm_sized_pipe.sv
// RV32 sized-access data RAM (LB/LH/LW/LBU/LHU, SB/SH/SW) with fault reporting, behind a valid/ready request port.
// Response READ_LATENCY cycles after accept; a held response freezes the whole pipe and drops req_ready.
module dm_sized_pipe #(
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]             mem [DEPTH];
  logic [READ_LATENCY-1:0] st_vld;
  logic [READ_LATENCY-1:0] st_err;
  logic [31:0]             st_rdata [READ_LATENCY];

  logic             advance;
  logic             accept;
  logic             sz_byte;
  logic             sz_half;
  logic             sz_word;
  logic             ld_unsigned;
  logic             bad_code;
  logic             misaligned;
  logic             out_of_range;
  logic             err;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;

  assign resp_valid = st_vld[READ_LATENCY-1];
  assign resp_err   = st_err[READ_LATENCY-1];
  assign resp_rdata = st_rdata[READ_LATENCY-1];
  assign advance    = !(resp_valid && !resp_ready);
  assign req_ready  = advance;
  assign accept     = req_valid && advance;

  always_comb begin
    sz_byte     = 1'b0;
    sz_half     = 1'b0;
    sz_word     = 1'b0;
    ld_unsigned = 1'b0;
    bad_code    = 1'b0;
    case (req_funct3)
      3'b000: sz_byte = 1'b1;
      3'b001: sz_half = 1'b1;
      3'b010: sz_word = 1'b1;
      3'b100: begin
        sz_byte     = 1'b1;
        ld_unsigned = 1'b1;
        bad_code    = req_write;
      end
      3'b101: begin
        sz_half     = 1'b1;
        ld_unsigned = 1'b1;
        bad_code    = req_write;
      end
      default: bad_code = 1'b1;
    endcase
  end

  assign misaligned   = (sz_half && req_addr[0]) || (sz_word && (req_addr[1:0] != 2'b00));
  assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;
  assign err          = bad_code || misaligned || out_of_range;
  assign idx          = req_addr[IDX_W+1:2];
  assign rd_word      = mem[idx];

  always_comb begin
    ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_addr[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    if (sz_byte)
      ld_data = ld_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    else if (sz_half)
      ld_data = ld_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    else
      ld_data = rd_word;
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    if (sz_word) begin
      wr_be   = 4'hF;
      wr_data = req_wdata;
    end else if (sz_half) begin
      wr_be   = req_addr[1] ? 4'hC : 4'h3;
      wr_data = {2{req_wdata[15:0]}};
    end else begin
      wr_be   = 4'h1 << req_addr[1:0];
      wr_data = {4{req_wdata[7:0]}};
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld <= '0;
      st_err <= '0;
      for (int i = 0; i < READ_LATENCY; i++) st_rdata[i] <= 32'h0;
    end else if (advance) begin
      st_vld[0]   <= accept;
      st_err[0]   <= accept && err;
      st_rdata[0] <= (accept && !err && !req_write) ? ld_data : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        st_vld[i]   <= st_vld[i-1];
        st_err[i]   <= st_err[i-1];
        st_rdata[i] <= st_rdata[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dm_sized_pipe.sv
// Two DUTs (latency 1 and 3) checked every cycle against a byte-addressed memory model with due-time response queues.
module tb_dm_sized_pipe;
  localparam int DEPTH = 64;
  localparam int NSEQ  = 16;

  typedef struct { int tgt; logic err; logic [31:0] rdata; } exp_t;
  typedef struct { int cyc; logic err; logic [31:0] rdata; } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [7:0] mmem [4*DEPTH];
    exp_t expq [$];
    obs_t logq [$];
    int   adv_cnt = 0;

    dm_sized_pipe #(.DEPTH(DEPTH), .READ_LATENCY(LAT), .ADDR_W(32)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );

    function automatic exp_t model(logic wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
      exp_t        r;
      int          sz;
      logic [31:0] v;
      r.tgt   = 0;
      r.err   = 1'b0;
      r.rdata = 32'h0;
      sz = 1 << f3[1:0];
      if (f3[1:0] == 2'b11 || (f3[2] && (f3[1] || wr)) || (a % sz) != 0 || a >= 4*DEPTH) begin
        r.err = 1'b1;
        return r;
      end
      if (wr) begin
        for (int k = 0; k < sz; k++) mmem[a+k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < sz; k++) v[8*k +: 8] = mmem[a+k];
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        else if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        r.rdata = v;
      end
      return r;
    endfunction

    always @(posedge clk) begin
      if (rst_n) begin
        bit   due;
        bit   adv;
        exp_t e;
        due = 1'b0;
        if (expq.size() > 0) due = (expq[0].tgt == adv_cnt);
        adv = !(due && !resp_ready[g]);
        if (resp_valid[g] && resp_ready[g]) logq.push_back('{cyc, resp_err[g], resp_rdata[g]});
        if (due && resp_ready[g]) void'(expq.pop_front());
        if (adv) begin
          adv_cnt++;
          if (req_valid[g]) begin
            e = model(req_write[g], req_funct3[g], req_addr[g], req_wdata[g]);
            e.tgt = adv_cnt + LAT - 1;
            expq.push_back(e);
          end
        end
      end
    end

    always @(negedge rst_n) expq.delete();

    always @(negedge clk) begin
      if (rst_n) begin
        bit due;
        due = 1'b0;
        if (expq.size() > 0) due = (expq[0].tgt == adv_cnt);
        chk($sformatf("d%0d resp_valid", g), 32'(resp_valid[g]), 32'(due));
        chk($sformatf("d%0d req_ready", g), 32'(req_ready[g]), 32'(!(due && !resp_ready[g])));
        if (due) begin
          chk($sformatf("d%0d resp_rdata", g), resp_rdata[g], expq[0].rdata);
          chk($sformatf("d%0d resp_err", g), 32'(resp_err[g]), 32'(expq[0].err));
        end
      end
    end
  end

  // Directed sequence for the latency-1 DUT: {write, funct3, addr, wdata} and expected {err, rdata}.
  logic        sq_wr [NSEQ] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0};
  logic [2:0]  sq_f3 [NSEQ] = '{2, 2, 0, 0, 0, 4, 5, 1, 2, 1, 2, 2, 2, 3, 4, 2};
  logic [31:0] sq_a  [NSEQ] = '{'h10, 'h10, 'h11, 'h11, 'h13, 'h13, 'h12, 'h12,
                                'h20, 'h21, 'h20, 'h22, 'h100, 'h10, 'h10, 'h10};
  logic [31:0] sq_wd [NSEQ] = '{'hDEADBEEF, 0, 'h7F, 0, 0, 0, 0, 0,
                                'h12345678, 'hBEEF, 0, 0, 0, 0, 'hAA, 0};
  logic        sq_er [NSEQ] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0};
  logic [31:0] sq_rd [NSEQ] = '{0, 'hDEADBEEF, 0, 'h7F, 'hFFFFFFDE, 'hDE, 'hDEAD, 'hFFFFDEAD,
                                0, 0, 'h12345678, 0, 0, 0, 0, 'hDEAD7FEF};

  task automatic send(int d, logic wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    bit done;
    done = 1'b0;
    req_valid[d] = 1'b1; req_write[d] = wr; req_funct3[d] = f3; req_addr[d] = a; req_wdata[d] = wd;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = req_ready[d];
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send d%0d timeout: req_ready stayed %b, required 1", d, req_ready[d]);
    end
  endtask

  task automatic idle_wait(int n);
    for (int d = 0; d < 2; d++) req_valid[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b1;
    end
    #1 rst_n = 1'b0;
    #11;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset resp_valid", d), 32'(resp_valid[d]), 0);
      chk($sformatf("d%0d reset resp_rdata", d), resp_rdata[d], 0);
      chk($sformatf("d%0d reset resp_err", d), 32'(resp_err[d]), 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("d%0d ready after reset", d), 32'(req_ready[d]), 1);
    @(posedge clk); #1;

    // Fill both arrays with known data so every later load is defined.
    for (int w = 0; w < DEPTH; w++) begin
      for (int d = 0; d < 2; d++) begin
        req_valid[d] = 1'b1; req_write[d] = 1'b1; req_funct3[d] = 3'd2;
        req_addr[d] = 32'(4*w); req_wdata[d] = $urandom;
      end
      @(posedge clk); #1;
    end
    idle_wait(6);

    g_dut[0].logq.delete();
    for (int i = 0; i < NSEQ; i++) send(0, sq_wr[i], sq_f3[i], sq_a[i], sq_wd[i]);
    idle_wait(6);
    chk("seq response count", g_dut[0].logq.size(), NSEQ);
    for (int i = 0; i < NSEQ && i < g_dut[0].logq.size(); i++) begin
      chk($sformatf("seq[%0d] err", i), 32'(g_dut[0].logq[i].err), 32'(sq_er[i]));
      chk($sformatf("seq[%0d] rdata", i), g_dut[0].logq[i].rdata, sq_rd[i]);
      chk($sformatf("seq[%0d] spacing", i), g_dut[0].logq[i].cyc - g_dut[0].logq[0].cyc, i);
    end

    // Latency-3 stall: A held for two cycles, then A, B, C one per cycle.
    send(1, 1, 3'd2, 32'h40, 32'h11111111);
    send(1, 1, 3'd2, 32'h44, 32'h22222222);
    send(1, 1, 3'd2, 32'h48, 32'h33333333);
    idle_wait(6);
    g_dut[1].logq.delete();
    send(1, 0, 3'd2, 32'h40, 0);
    send(1, 0, 3'd2, 32'h44, 0);
    send(1, 0, 3'd2, 32'h48, 0);
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d resp_valid", s), 32'(resp_valid[1]), 1);
      chk($sformatf("stall%0d hold A", s), resp_rdata[1], 32'h11111111);
      chk($sformatf("stall%0d req_ready", s), 32'(req_ready[1]), 0);
      @(posedge clk); #1;
    end
    resp_ready[1] = 1'b1;
    idle_wait(6);
    chk("stall count", g_dut[1].logq.size(), 3);
    if (g_dut[1].logq.size() == 3) begin
      chk("stall A", g_dut[1].logq[0].rdata, 32'h11111111);
      chk("stall B", g_dut[1].logq[1].rdata, 32'h22222222);
      chk("stall C", g_dut[1].logq[2].rdata, 32'h33333333);
      chk("stall B spacing", g_dut[1].logq[1].cyc - g_dut[1].logq[0].cyc, 1);
      chk("stall C spacing", g_dut[1].logq[2].cyc - g_dut[1].logq[1].cyc, 1);
    end

    // Reset with two loads in flight: both are discarded, the array survives.
    send(1, 1, 3'd2, 32'h80, 32'hCAFEF00D);
    idle_wait(6);
    g_dut[1].logq.delete();
    send(1, 0, 3'd2, 32'h80, 0);
    send(1, 0, 3'd2, 32'h84, 0);
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre-reset resp_valid", 32'(resp_valid[1]), 1);
    #1 rst_n = 1'b0;
    #1 chk("reset drops resp_valid", 32'(resp_valid[1]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready after mid reset", 32'(req_ready[1]), 1);
    idle_wait(6);
    chk("discarded responses", g_dut[1].logq.size(), 0);
    send(1, 0, 3'd2, 32'h80, 0);
    idle_wait(6);
    chk("post-reset load count", g_dut[1].logq.size(), 1);
    if (g_dut[1].logq.size() == 1) chk("post-reset load data", g_dut[1].logq[0].rdata, 32'hCAFEF00D);

    // Random traffic with random backpressure on both DUTs.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        logic [2:0]  f3;
        logic [31:0] a;
        case ($urandom_range(0, 5))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          4: f3 = 3'd5;
          default: f3 = 3'($urandom_range(0, 7));
        endcase
        a = $urandom_range(0, 4*DEPTH-1);
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        if ($urandom_range(0, 9) == 0) a = a + 4*DEPTH;
        if ($urandom_range(0, 19) == 0) a[31] = 1'b1;
        req_valid[d]  = ($urandom_range(0, 3) != 0);
        req_write[d]  = 1'($urandom_range(0, 1));
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = $urandom;
        resp_ready[d] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) resp_ready[d] = 1'b1;
    idle_wait(10);
    chk("d0 drained", g_dut[0].expq.size(), 0);
    chk("d1 drained", g_dut[1].expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
